// File: rtl/arp_reply_gen_if.sv
// Receive-parser ARP field strobe and byte-wide TX stream between the parser,
// the reply generator and the GMII output stage.
interface arp_reply_gen_if;
    logic        i_pkt_vl;
    logic [1:0]  i_pkt_type;
    logic [47:0] i_SHA;
    logic [31:0] i_SPA;
    logic [31:0] i_TPA;
    logic [7:0]  o_data;
    logic        o_tx_en;

    modport master (output i_pkt_vl, i_pkt_type, i_SHA, i_SPA, i_TPA,
                    input  o_data, o_tx_en);
    modport slave  (input  i_pkt_vl, i_pkt_type, i_SHA, i_SPA, i_TPA,
                    output o_data, o_tx_en);
endinterface

// File: rtl/arp_reply_gen.sv
// Builds a padded 64-byte ARP reply frame (with preamble/SFD/FCS) for each ARP
// request addressed to our IP; one further request can wait in a pending slot.
module arp_reply_gen #(
    parameter int         PREAMBLE_LEN = 7,
    parameter int         IFG_CYCLES   = 12,
    parameter logic [1:0] REQ_TYPE     = 2'b01
) (
    input  logic               clk,
    input  logic               rst_n,
    arp_reply_gen_if.slave     bus,
    input  logic [47:0]        i_self_mac,
    input  logic [31:0]        i_self_ip,
    output logic               o_busy,
    output logic [7:0]         o_drop_cnt
);
    typedef enum logic [2:0] {IDLE, PRE, HDR, PAD, FCS, IFG} state_t;

    localparam logic [6:0] PRE_LAST = 7'(PREAMBLE_LEN);
    localparam logic [6:0] IFG_LAST = 7'(IFG_CYCLES - 1);

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        acc_q, acc_d;
    logic [47:0] req_sha_q, req_sha_d;
    logic [31:0] req_spa_q, req_spa_d;
    logic [47:0] act_sha_q, act_sha_d;
    logic [31:0] act_spa_q, act_spa_d;
    logic [47:0] pend_sha_q, pend_sha_d;
    logic [31:0] pend_spa_q, pend_spa_d;
    logic        pend_full_q, pend_full_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  data_q, data_d;
    logic        tx_en_q, tx_en_d;
    logic        busy_q, busy_d;
    logic [7:0]  drop_q, drop_d;

    logic [335:0] hdr_w, hdr_sh;
    logic [31:0]  fcs_sh;
    logic [7:0]   cur_byte;
    logic         ifg_done;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign hdr_w  = {act_sha_q, i_self_mac, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
                     16'h0002, i_self_mac, i_self_ip, act_sha_q, act_spa_q};
    assign hdr_sh = hdr_w << {cnt_q, 3'b000};
    assign fcs_sh = (~crc_q) >> {cnt_q[1:0], 3'b000};
    assign ifg_done = (state_q == IFG) && (cnt_q == IFG_LAST);

    always_comb begin
        acc_d       = bus.i_pkt_vl && (bus.i_pkt_type == REQ_TYPE) && (bus.i_TPA == i_self_ip);
        req_sha_d   = bus.i_SHA;
        req_spa_d   = bus.i_SPA;
        state_d     = state_q;
        act_sha_d   = act_sha_q;
        act_spa_d   = act_spa_q;
        pend_sha_d  = pend_sha_q;
        pend_spa_d  = pend_spa_q;
        pend_full_d = pend_full_q;
        drop_d      = drop_q;
        crc_d       = crc_q;
        cur_byte    = 8'h00;

        case (state_q)
            PRE:     cur_byte = (cnt_q < PRE_LAST) ? 8'h55 : 8'hD5;
            HDR:     cur_byte = hdr_sh[335:328];
            FCS:     cur_byte = fcs_sh[7:0];
            default: cur_byte = 8'h00;
        endcase
        data_d  = cur_byte;
        tx_en_d = (state_q == PRE) || (state_q == HDR) || (state_q == PAD) || (state_q == FCS);

        // CRC restarts during the preamble so it covers exactly dst MAC .. last pad byte
        if (state_q == PRE)
            crc_d = 32'hFFFFFFFF;
        else if (state_q == HDR || state_q == PAD)
            crc_d = crc32_byte(crc_q, cur_byte);

        case (state_q)
            PRE: if (cnt_q == PRE_LAST) state_d = HDR;
            HDR: if (cnt_q == 7'd41)    state_d = PAD;
            PAD: if (cnt_q == 7'd17)    state_d = FCS;
            FCS: if (cnt_q == 7'd3)     state_d = IFG;
            IFG: if (ifg_done)          state_d = IDLE;
            default: ;
        endcase

        if (ifg_done && pend_full_q) begin
            state_d     = PRE;
            act_sha_d   = pend_sha_q;
            act_spa_d   = pend_spa_q;
            pend_full_d = 1'b0;
        end

        // A slot emptied on this edge is immediately refillable
        if (acc_q) begin
            if (state_q == IDLE || (ifg_done && !pend_full_q)) begin
                state_d   = PRE;
                act_sha_d = req_sha_q;
                act_spa_d = req_spa_q;
            end else if (!pend_full_q || ifg_done) begin
                pend_sha_d  = req_sha_q;
                pend_spa_d  = req_spa_q;
                pend_full_d = 1'b1;
            end else begin
                drop_d = sat_inc(drop_q);
            end
        end

        cnt_d  = (state_d != state_q || state_q == IDLE) ? 7'd0 : cnt_q + 7'd1;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        req_sha_q  <= req_sha_d;
        req_spa_q  <= req_spa_d;
        act_sha_q  <= act_sha_d;
        act_spa_q  <= act_spa_d;
        pend_sha_q <= pend_sha_d;
        pend_spa_q <= pend_spa_d;
        crc_q      <= crc_d;
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 7'd0;
            acc_q       <= 1'b0;
            pend_full_q <= 1'b0;
            data_q      <= 8'h00;
            tx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            pend_full_q <= pend_full_d;
            data_q      <= data_d;
            tx_en_q     <= tx_en_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_tx_en = tx_en_q;
    assign o_busy      = busy_q;
    assign o_drop_cnt  = drop_q;
endmodule

// File: tb/tb_arp_reply_gen.sv
// Directed bench for arp_reply_gen: reset idle, reply frame content and FCS,
// filtering, back-to-back pending frame, mid-frame reset and drop saturation.
module tb_arp_reply_gen;
    localparam logic [47:0] SELF_MAC = 48'h0023543C471B;
    localparam logic [31:0] SELF_IP  = 32'h0A000021;

    logic clk;
    logic rst_n;
    logic [7:0] drop_cnt;
    logic busy;
    int n_checks;
    int n_errors;

    logic [7:0] frame_buf [0:79];
    int         frame_len;
    logic [7:0] exp_buf [0:71];

    arp_reply_gen_if bus();

    arp_reply_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .i_self_mac (SELF_MAC),
        .i_self_ip  (SELF_IP),
        .o_busy     (busy),
        .o_drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] b);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    task automatic build_frame(input logic [47:0] sha, input logic [31:0] spa);
        logic [31:0] c;
        logic [335:0] h;
        h = {sha, SELF_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
             16'h0002, SELF_MAC, SELF_IP, sha, spa};
        for (int i = 0; i < 7; i++) exp_buf[i] = 8'h55;
        exp_buf[7] = 8'hD5;
        for (int i = 0; i < 42; i++) exp_buf[8+i] = h[335-8*i -: 8];
        for (int i = 50; i < 68; i++) exp_buf[i] = 8'h00;
        c = 32'hFFFFFFFF;
        for (int i = 8; i < 68; i++) c = crc_bits(c, exp_buf[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) exp_buf[68+i] = c[8*i +: 8];
    endtask

    task automatic drive_req(input logic [47:0] sha, input logic [31:0] spa,
                             input logic [31:0] tpa, input logic [1:0] typ);
        bus.i_pkt_vl   = 1'b1;
        bus.i_pkt_type = typ;
        bus.i_SHA      = sha;
        bus.i_SPA      = spa;
        bus.i_TPA      = tpa;
        @(negedge clk);
        bus.i_pkt_vl   = 1'b0;
    endtask

    task automatic wait_tx(input string tag);
        int k;
        k = 0;
        while (!bus.o_tx_en && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, {63'h0, bus.o_tx_en}, 64'h1);
    endtask

    task automatic grab();
        frame_len = 0;
        while (bus.o_tx_en && frame_len < 80) begin
            frame_buf[frame_len] = bus.o_data;
            frame_len++;
            @(negedge clk);
        end
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_len"}, 64'(frame_len), 64'd72);
        for (int i = 0; i < 72; i++)
            check($sformatf("%s_b%0d", tag, i), {56'h0, frame_buf[i]}, {56'h0, exp_buf[i]});
    endtask

    initial begin
        int cnt_tx, cnt_busy, cnt_data, cnt_drop, gap, busy_low;
        logic [31:0] res, rev;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.i_pkt_vl = 1'b0;
        bus.i_pkt_type = 2'b00;
        bus.i_SHA = '0;
        bus.i_SPA = '0;
        bus.i_TPA = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        cnt_tx = 0; cnt_busy = 0; cnt_data = 0; cnt_drop = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.o_tx_en) cnt_tx++;
            if (busy) cnt_busy++;
            if (bus.o_data != 8'h00) cnt_data++;
            if (drop_cnt != 8'h00) cnt_drop++;
        end
        check("rst_tx_en", 64'(cnt_tx), 64'd0);
        check("rst_busy", 64'(cnt_busy), 64'd0);
        check("rst_data", 64'(cnt_data), 64'd0);
        check("rst_drop", 64'(cnt_drop), 64'd0);

        // single request: latency and content
        build_frame(48'h0c54a5312485, 32'h0A000002);
        drive_req(48'h0c54a5312485, 32'h0A000002, SELF_IP, 2'b01);
        check("lat_n_txen", {63'h0, bus.o_tx_en}, 64'h0);
        @(negedge clk);
        check("lat_n1_busy", {63'h0, busy}, 64'h1);
        check("lat_n1_txen", {63'h0, bus.o_tx_en}, 64'h0);
        @(negedge clk);
        check("lat_n2_txen", {63'h0, bus.o_tx_en}, 64'h1);
        check("lat_n2_data", {56'h0, bus.o_data}, 64'h55);
        grab();
        compare_frame("f1");
        check("f1_dst", {16'h0, frame_buf[8], frame_buf[9], frame_buf[10], frame_buf[11],
                         frame_buf[12], frame_buf[13]}, 64'h0c54a5312485);
        check("f1_oper", {48'h0, frame_buf[28], frame_buf[29]}, 64'h0002);
        check("f1_tpa", {32'h0, frame_buf[46], frame_buf[47], frame_buf[48], frame_buf[49]},
              64'h0A000002);
        res = 32'hFFFFFFFF;
        for (int i = 8; i < 72; i++) res = crc_bits(res, frame_buf[i]);
        for (int i = 0; i < 32; i++) rev[i] = res[31-i];
        check("f1_residue", {32'h0, rev}, 64'hC704DD7B);
        repeat (20) @(negedge clk);
        check("f1_busy_end", {63'h0, busy}, 64'h0);

        // filtered strobes
        drive_req(48'h111111111111, 32'h0A000005, 32'h0A000022, 2'b01);
        drive_req(48'h222222222222, 32'h0A000006, SELF_IP, 2'b10);
        cnt_tx = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.o_tx_en) cnt_tx++;
        end
        check("filt_tx", 64'(cnt_tx), 64'd0);
        check("filt_drop", {56'h0, drop_cnt}, 64'd0);

        // three requests on consecutive cycles
        bus.i_pkt_vl = 1'b1; bus.i_pkt_type = 2'b01; bus.i_TPA = SELF_IP;
        bus.i_SHA = 48'hA1A2A3A4A5A6; bus.i_SPA = 32'h0A000010;
        @(negedge clk);
        bus.i_SHA = 48'hB1B2B3B4B5B6; bus.i_SPA = 32'h0A000011;
        @(negedge clk);
        bus.i_SHA = 48'hC1C2C3C4C5C6; bus.i_SPA = 32'h0A000012;
        @(negedge clk);
        bus.i_pkt_vl = 1'b0;
        wait_tx("b2b_start1");
        grab();
        build_frame(48'hA1A2A3A4A5A6, 32'h0A000010);
        compare_frame("b2b1");
        gap = 0; busy_low = 0;
        while (!bus.o_tx_en && gap < 100) begin
            if (!busy) busy_low++;
            gap++;
            @(negedge clk);
        end
        check("b2b_gap", 64'(gap), 64'd12);
        check("b2b_busy_gap", 64'(busy_low), 64'd0);
        grab();
        build_frame(48'hB1B2B3B4B5B6, 32'h0A000011);
        compare_frame("b2b2");
        check("b2b_drop", {56'h0, drop_cnt}, 64'd1);
        cnt_tx = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.o_tx_en) cnt_tx++;
        end
        check("b2b_no_third", 64'(cnt_tx), 64'd0);
        check("b2b_idle", {63'h0, busy}, 64'h0);

        // reset in the middle of the header
        drive_req(48'h0c54a5312485, 32'h0A000002, SELF_IP, 2'b01);
        wait_tx("mid_start");
        repeat (28) @(negedge clk);
        check("mid_b28", {56'h0, bus.o_data}, 64'h00);
        check("mid_b28_en", {63'h0, bus.o_tx_en}, 64'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_txen", {63'h0, bus.o_tx_en}, 64'h0);
        check("mid_rst_busy", {63'h0, busy}, 64'h0);
        check("mid_rst_drop", {56'h0, drop_cnt}, 64'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_quiet", {63'h0, bus.o_tx_en}, 64'h0);
        drive_req(48'h5A5B5C5D5E5F, 32'h0A0000FE, SELF_IP, 2'b01);
        wait_tx("post_rst_start");
        grab();
        build_frame(48'h5A5B5C5D5E5F, 32'h0A0000FE);
        compare_frame("post_rst");
        repeat (30) @(negedge clk);

        // drop counting and saturation
        bus.i_pkt_vl = 1'b1; bus.i_pkt_type = 2'b01; bus.i_TPA = SELF_IP;
        bus.i_SHA = 48'h0000000000AA; bus.i_SPA = 32'h0A000030;
        repeat (12) @(negedge clk);
        bus.i_pkt_vl = 1'b0;
        @(negedge clk);
        check("drop_10", {56'h0, drop_cnt}, 64'd10);
        bus.i_pkt_vl = 1'b1;
        repeat (310) @(negedge clk);
        bus.i_pkt_vl = 1'b0;
        @(negedge clk);
        check("drop_sat", {56'h0, drop_cnt}, 64'd255);
        repeat (5) @(negedge clk);
        check("drop_hold", {56'h0, drop_cnt}, 64'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/arp_reply_gen.md
Name: arp_reply_gen

Overview:
Downstream consumer of the Ethernet receive parser's ARP field outputs. When an ARP request for our IP arrives, it builds a complete 64-byte ARP reply frame with preamble, SFD, padding and FCS. It streams the frame byte-wise onto the 8-bit TX path (o_data/o_tx_en) that feeds the tx_ddio GMII output stage. A single-entry pending slot absorbs one request that arrives while a reply is still being sent.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes sent before SFD 0xD5
IFG_CYCLES, 12, idle cycles with o_tx_en=0 enforced after each frame
REQ_TYPE, 2'b01, i_pkt_type code meaning "ARP request"

Ports:
clk  input  1  single clock (TX pll domain); all inputs already synchronous to it
rst_n  input  1  synchronous active-low reset
i_pkt_vl  input  1  one-cycle strobe: parsed fields valid for this cycle
i_pkt_type  input  2  parsed packet type (01 request, 10 reply, 00 other)
i_SHA  input  48  sender hardware address of received ARP
i_SPA  input  32  sender protocol address of received ARP
i_TPA  input  32  target protocol address of received ARP
i_self_mac  input  48  our MAC address (static)
i_self_ip  input  32  our IP address (static)
o_data  output  8  TX byte
o_tx_en  output  1  TX byte valid / frame active
o_busy  output  1  high from accept until end of IFG
o_drop_cnt  output  8  saturating count of dropped requests

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, o_data=0, o_tx_en=0, o_busy=0, o_drop_cnt=0, pending slot empty. Reset mid-frame aborts the frame immediately; o_tx_en is 0 on the next cycle.
- Accept condition: i_pkt_vl=1 and i_pkt_type==REQ_TYPE and i_TPA==i_self_ip. All other strobes are ignored and are not counted as drops.
- Accepted request: SHA/SPA latched. If IDLE, load into the active registers and start the frame. If busy and the pending slot is empty, store in the pending slot. If busy and the pending slot is full, drop the request and increment o_drop_cnt (saturates at 255).
- Latency: strobe at edge N (IDLE) -> o_tx_en=1 with o_data=0x55 from edge N+2. o_busy=1 from edge N+1.
- States: IDLE -> PRE (PREAMBLE_LEN x 0x55, then 0xD5) -> HDR (42 bytes) -> PAD (18 x 0x00) -> FCS (4 bytes) -> IFG (IFG_CYCLES cycles, o_tx_en=0, o_data=0).
- Leaving IFG: go to PRE if the pending slot is full (move it to active, clear slot; o_busy stays 1); otherwise go to IDLE.
- o_tx_en is 1 continuously from the first preamble byte through the last FCS byte: 8+64 = 72 cycles at default parameters.
- HDR byte order, MSB byte first:
  - dst = latched SHA; src = i_self_mac; ethertype 0x0806
  - HTYPE 0x0001, PTYPE 0x0800, HLEN 0x06, PLEN 0x04, OPER 0x0002
  - SHA = i_self_mac, SPA = i_self_ip, THA = latched SHA, TPA = latched SPA
- FCS: IEEE CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF, byte-wise update LSB-first over dst MAC through last pad byte (60 bytes). Output the complemented CRC, least significant byte first. The CRC re-initialises at SFD.
- Byte counter is 7 bits, cleared on each state change; no wrap occurs within a state.
- Simultaneous events:
  - Accept strobe on the same edge the FSM leaves IFG with the slot empty: the request is taken directly as active (PRE next), not stored.
  - Accept strobe on the same edge the slot is emptied: the new request fills the slot.
- i_self_mac/i_self_ip are sampled live. They must be static during operation.

Test Plan:
- Reset, no stimulus -> o_tx_en=0, o_busy=0, o_data=0, o_drop_cnt=0 for 100 cycles.
- Request: i_SHA=0c54a5312485, i_SPA=0A000002, i_TPA=0A000021, self_ip=0A000021, self_mac=0023543C471B -> first 0x55 at N+2; 72 enabled bytes; dst bytes 0c 54 a5 31 24 85; OPER 00 02; TPA 0A 00 00 02; CRC-32 over bytes 8..71 gives residue 0xC704DD7B and matches the software model.
- Non-matching i_TPA=0A000022, and i_pkt_type=2'b10 with matching TPA -> no o_tx_en, o_drop_cnt=0.
- Three requests 1 cycle apart -> two back-to-back frames separated by exactly 12 idle cycles; o_drop_cnt=1; o_busy stays 1 across the gap.
- rst_n=0 for 1 cycle at HDR byte 20 -> o_tx_en=0 next cycle; the next request produces a fully correct frame.
- 300 overflow drops -> o_drop_cnt saturates at 255.
